// File: rtl/spi_slave_cfg.sv
// spi_slave_cfg: parametrised SPI slave running entirely in the system clock domain.
// sck, ss and mosi are oversampled through synchronisers. Edges of the synchronised
// sck and ss are used to shift words in and out. Back-to-back words are supported
// while ss stays low. tx and rx each have a valid/ready handshake.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   sck_i          SPI clock from master (asynchronous)
//   ss_i           slave select, active-low (asynchronous)
//   mosi_i         master-out data (asynchronous)
//   miso_o         slave-out data
//   tx_data_i      next word to transmit
//   tx_valid_i     tx_data_i valid
//   tx_ready_o     tx holding register empty
//   rx_data_o      last received word
//   rx_valid_o     rx_data_o holds an unconsumed word
//   rx_ready_i     consumer accepts rx_data_o
//   rx_overrun_o   sticky: a received word overwrote an unconsumed one
//   tx_underrun_o  one-cycle pulse: a word was loaded while the holding register was empty
//   busy_o         slave is selected (synchronised ss low)
`timescale 1ns/1ps
module spi_slave_cfg #(
    parameter int unsigned DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sck_i,
    input  logic              ss_i,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              rx_overrun_o,
    output logic              tx_underrun_o,
    output logic              busy_o
);

    localparam int unsigned   CntW    = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_d1_q, ss_d1_q;
    logic [CntW-1:0]        cnt_q;
    logic [DATA_W-1:0]      tx_sh_q, rx_sh_q, hold_q, rx_data_q;
    logic                   hold_full_q, miso_q, rx_valid_q, rx_overrun_q, tx_underrun_q;

    logic              sck_s, ss_s, mosi_s;
    logic              sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic              ss_fall, ss_rise, word_done, tx_take;
    logic [DATA_W-1:0] load_word, rx_next;

    // Bit that goes on the line first for a given word.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    // Word with its first-out bit removed.
    function automatic logic [DATA_W-1:0] drop_first(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    always_comb begin
        sck_s       = sck_sync_q[SYNC_STAGES-1];
        ss_s        = ss_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sck_rise    = sck_s & ~sck_d1_q;
        sck_fall    = ~sck_s & sck_d1_q;
        lead_edge   = CPOL ? sck_fall : sck_rise;
        trail_edge  = CPOL ? sck_rise : sck_fall;
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
        ss_fall     = ss_d1_q & ~ss_s;
        ss_rise     = ~ss_d1_q & ss_s;
        word_done   = (state_q == StActive) && sample_edge && (cnt_q == LastCnt);
        // A word completing together with deselect does not start a new word.
        tx_take     = ((state_q == StIdle) && ss_fall) || (word_done && !ss_rise);
        load_word   = hold_full_q ? hold_q : '0;
        rx_next     = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], mosi_s} : {mosi_s, rx_sh_q[DATA_W-1:1]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q  <= {SYNC_STAGES{CPOL}};
            ss_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
            sck_d1_q    <= CPOL;
            ss_d1_q     <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sck_d1_q    <= sck_s;
            ss_d1_q     <= ss_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            tx_sh_q       <= '0;
            rx_sh_q       <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            miso_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            tx_underrun_q <= tx_take && !hold_full_q;
            if (rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end

            // Handshake only happens when empty, so it never collides with a take of a full word.
            if (tx_valid_i && !hold_full_q) begin
                hold_q      <= tx_data_i;
                hold_full_q <= 1'b1;
            end else if (tx_take) begin
                hold_full_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    miso_q <= 1'b0;
                    cnt_q  <= '0;
                    if (ss_fall) begin
                        state_q <= StActive;
                        if (!CPHA) begin
                            miso_q  <= first_bit(load_word);
                            tx_sh_q <= drop_first(load_word);
                        end else begin
                            tx_sh_q <= load_word;
                        end
                    end
                end
                StActive: begin
                    if (sample_edge) begin
                        if (word_done) begin
                            rx_data_q  <= rx_next;
                            rx_valid_q <= 1'b1;
                            if (rx_valid_q && !rx_ready_i) begin
                                rx_overrun_q <= 1'b1;
                            end
                            cnt_q <= '0;
                        end else begin
                            rx_sh_q <= rx_next;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                    if (ss_rise) begin
                        state_q <= StIdle;
                        miso_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (word_done) begin
                        if (!CPHA) begin
                            miso_q  <= first_bit(load_word);
                            tx_sh_q <= drop_first(load_word);
                        end else begin
                            tx_sh_q <= load_word;
                        end
                    end else if (shift_edge && (CPHA || (cnt_q != '0))) begin
                        // CPHA=0: the shift edge right after a word boundary must not
                        // advance, the new word's first bit is already on the line.
                        miso_q  <= first_bit(tx_sh_q);
                        tx_sh_q <= drop_first(tx_sh_q);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign miso_o        = miso_q;
    assign tx_ready_o    = ~hold_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_overrun_o  = rx_overrun_q;
    assign tx_underrun_o = tx_underrun_q;
    assign busy_o        = (state_q == StActive);

endmodule
